// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_sched
//  Description : Round-robin, message-locked scheduler and 8N1 serialiser
//                sharing one management UART TX pin between NREQ requesters.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_sched #(
    parameter int NREQ         = 4,
    parameter int DIV_W        = 16,
    parameter int HOLD_TIMEOUT = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [DIV_W-1:0]    clkdiv,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*8-1:0]   req_data,
    input  logic [NREQ-1:0]     req_last,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     grant,
    output logic                busy,
    output logic                ser_tx
);

    localparam int c_IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_HW = $clog2(HOLD_TIMEOUT + 1);

    localparam logic [c_IW-1:0] c_LAST_IDX  = c_IW'(NREQ - 1);
    localparam logic [c_HW-1:0] c_HOLD_LAST = c_HW'(HOLD_TIMEOUT - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_START = 3'd1;
    localparam logic [2:0] c_ST_DATA  = 3'd2;
    localparam logic [2:0] c_ST_STOP  = 3'd3;
    localparam logic [2:0] c_ST_HOLD  = 3'd4;

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [c_IW-1:0]  r_owner;
    logic [c_IW-1:0]  r_rr_ptr;
    logic [NREQ-1:0]  r_grant;
    logic [7:0]       r_shift;
    logic             r_last;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [c_HW-1:0]  r_hold;

    logic [c_IW-1:0]  w_winner;
    logic             w_any_valid;
    logic             w_bit_end;
    logic             w_capture;
    logic             w_release;
    logic [c_IW-1:0]  w_cap_idx;
    logic [7:0]       w_cap_byte;
    logic [NREQ-1:0]  w_cap_onehot;

    assign w_bit_end    = (r_cnt == r_div);
    assign w_cap_byte   = req_data[{w_cap_idx, 3'b000} +: 8];
    assign w_cap_onehot = NREQ'(1) << w_cap_idx;

    // Round-robin search: first valid requester at or above the pointer, wrapping
    always_comb begin
        logic [c_IW:0] v_idx;
        v_idx       = '0;
        w_winner    = '0;
        w_any_valid = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            v_idx = {1'b0, r_rr_ptr} + (c_IW + 1)'(k);
            if (v_idx >= (c_IW + 1)'(NREQ)) begin
                v_idx = v_idx - (c_IW + 1)'(NREQ);
            end
            if (!w_any_valid && req_valid[v_idx[c_IW-1:0]]) begin
                w_any_valid = 1'b1;
                w_winner    = v_idx[c_IW-1:0];
            end
        end
    end

    // Next-state logic; capture and release decisions are made here
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_release    = 1'b0;
        w_cap_idx    = r_owner;
        case (r_state)
            c_ST_IDLE: begin
                if (enable && w_any_valid) begin
                    w_capture    = 1'b1;
                    w_cap_idx    = w_winner;
                    w_next_state = c_ST_START;
                end
            end
            c_ST_START: begin
                if (w_bit_end) w_next_state = c_ST_DATA;
            end
            c_ST_DATA: begin
                if (w_bit_end && (r_bit == 3'd7)) w_next_state = c_ST_STOP;
            end
            c_ST_STOP: begin
                if (w_bit_end) begin
                    if (r_last || !enable) begin
                        w_release    = 1'b1;
                        w_next_state = c_ST_IDLE;
                    end else if (req_valid[r_owner]) begin
                        // Next byte of the message follows with no idle gap
                        w_capture    = 1'b1;
                        w_next_state = c_ST_START;
                    end else begin
                        w_next_state = c_ST_HOLD;
                    end
                end
            end
            c_ST_HOLD: begin
                if (!enable) begin
                    w_release    = 1'b1;
                    w_next_state = c_ST_IDLE;
                end else if (req_valid[r_owner]) begin
                    w_capture    = 1'b1;
                    w_next_state = c_ST_START;
                end else if (r_hold == c_HOLD_LAST) begin
                    w_release    = 1'b1;
                    w_next_state = c_ST_IDLE;
                end
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= c_ST_IDLE;
        else       r_state <= w_next_state;
    end

    // Datapath: byte capture, baud counting, shifting, grant and pointer updates
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_shift  <= '0;
            r_last   <= 1'b0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_hold   <= '0;
        end else begin
            r_hold <= (r_state == c_ST_HOLD) ? r_hold + c_HW'(1) : '0;
            if (w_capture) begin
                // Divisor is frozen per byte so mid-frame changes cannot distort it
                r_owner <= w_cap_idx;
                r_grant <= w_cap_onehot;
                r_shift <= w_cap_byte;
                r_last  <= req_last[w_cap_idx];
                r_div   <= clkdiv;
                r_cnt   <= '0;
                r_bit   <= '0;
            end else begin
                if ((r_state == c_ST_START) || (r_state == c_ST_DATA) ||
                    (r_state == c_ST_STOP)) begin
                    r_cnt <= w_bit_end ? '0 : r_cnt + DIV_W'(1);
                end
                if ((r_state == c_ST_DATA) && w_bit_end) begin
                    r_shift <= {1'b0, r_shift[7:1]};
                    r_bit   <= r_bit + 3'd1;
                end
            end
            if (w_release) begin
                r_grant  <= '0;
                r_rr_ptr <= (r_owner == c_LAST_IDX) ? '0 : r_owner + c_IW'(1);
            end
        end
    end

    // Line level decoded from state so an async reset forces idle-high at once
    always_comb begin
        ser_tx = 1'b1;
        if (r_state == c_ST_START)     ser_tx = 1'b0;
        else if (r_state == c_ST_DATA) ser_tx = r_shift[0];
    end

    assign req_ready = (w_capture && !reset) ? w_cap_onehot : '0;
    assign grant     = r_grant;
    assign busy      = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire
